// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the default-width complex sample type.
package fft_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 12;
    localparam int unsigned FRACTION_DEF   = 11;
    localparam int unsigned TW_WIDTH_DEF   = 12;
    localparam int unsigned BUT_LATENCY    = 3;

    typedef struct packed {
        logic signed [DATA_WIDTH_DEF-1:0] re;
        logic signed [DATA_WIDTH_DEF-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cmult_pipe.sv
// Two-stage pipelined complex multiply: b * tw, rounded half-up back to DATA_WIDTH+1 bits.
module cmult_pipe
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned TW_WIDTH   = TW_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [2*DATA_WIDTH-1:0]     b_in,
    input  logic [2*TW_WIDTH-1:0]       tw_in,
    output logic [2*(DATA_WIDTH+1)-1:0] wb_out
);

    localparam int unsigned PW = DATA_WIDTH + TW_WIDTH;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned OW = DATA_WIDTH + 1;
    localparam logic signed [SW-1:0] Rnd = SW'(1 << (TW_WIDTH - 2));

    typedef struct packed {
        logic [PW-1:0] rr;
        logic [PW-1:0] ii;
        logic [PW-1:0] ri;
        logic [PW-1:0] ir;
    } prod_t;

    prod_t                    prod_d, prod_q;
    logic [2*OW-1:0]          wb_d, wb_q;
    logic signed [DATA_WIDTH-1:0] b_re, b_im;
    logic signed [TW_WIDTH-1:0]   tw_re, tw_im;
    logic signed [SW-1:0]     re_rnd, im_rnd;
    logic                     unused_rnd;

    always_comb begin
        b_re   = b_in[2*DATA_WIDTH-1:DATA_WIDTH];
        b_im   = b_in[DATA_WIDTH-1:0];
        tw_re  = tw_in[2*TW_WIDTH-1:TW_WIDTH];
        tw_im  = tw_in[TW_WIDTH-1:0];
        prod_d = prod_q;
        if (en) begin
            prod_d.rr = PW'(b_re) * PW'(tw_re);
            prod_d.ii = PW'(b_im) * PW'(tw_im);
            prod_d.ri = PW'(b_re) * PW'(tw_im);
            prod_d.ir = PW'(b_im) * PW'(tw_re);
        end
        re_rnd = {prod_q.rr[PW-1], prod_q.rr} - {prod_q.ii[PW-1], prod_q.ii} + Rnd;
        im_rnd = {prod_q.ri[PW-1], prod_q.ri} + {prod_q.ir[PW-1], prod_q.ir} + Rnd;
        wb_d   = wb_q;
        // Slicing at TW_WIDTH-1 is the arithmetic right shift, keeping OW bits.
        if (en) begin
            wb_d = {re_rnd[TW_WIDTH-1 +: OW], im_rnd[TW_WIDTH-1 +: OW]};
        end
    end

    assign unused_rnd = ^{re_rnd[SW-1], re_rnd[TW_WIDTH-2:0], im_rnd[SW-1], im_rnd[TW_WIDTH-2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q <= '0;
            wb_q   <= '0;
        end else begin
            prod_q <= prod_d;
            wb_q   <= wb_d;
        end
    end

    assign wb_out = wb_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly with valid/ready backpressure and per-transaction halving.
// BUTTERFLY_SAT_EN defined: out-of-range results clamp; otherwise they wrap.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FRACTION   = FRACTION_DEF,
    parameter int unsigned TW_WIDTH   = TW_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    but_ready_in,
    input  logic                    but_valid_in,
    input  logic [2*DATA_WIDTH-1:0] but_a_in,
    input  logic [2*DATA_WIDTH-1:0] but_b_in,
    input  logic [2*TW_WIDTH-1:0]   but_tw,
    input  logic                    but_scale_in,
    input  logic                    but_ready_out,
    output logic                    but_valid_out,
    output logic [2*DATA_WIDTH-1:0] but_a_out,
    output logic [2*DATA_WIDTH-1:0] but_b_out,
    output logic                    but_ovf_out
);

    localparam int unsigned CW = 2 * DATA_WIDTH;
    localparam int unsigned WW = DATA_WIDTH + 1;
    localparam int unsigned EW = DATA_WIDTH + 2;

    typedef struct packed {
        logic          valid;
        logic          scale;
        logic [CW-1:0] a;
    } stage_t;

    stage_t          s1_d, s1_q, s2_d, s2_q;
    logic            en;
    logic [2*WW-1:0] wb;
    logic            valid_out_d, valid_out_q, ovf_d, ovf_q;
    logic [CW-1:0]   a_out_d, a_out_q, b_out_d, b_out_q;
    logic signed [DATA_WIDTH-1:0] a_re, a_im;
    logic signed [WW-1:0] wb_re, wb_im;
    logic signed [EW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic [DATA_WIDTH:0]  f_sr, f_si, f_dr, f_di;
    logic            unused_frac;

    assign unused_frac  = (FRACTION > DATA_WIDTH);
    assign en           = ~valid_out_q | but_ready_out;
    assign but_ready_in = en;

    // Returns {out_of_range, fitted value}.
    function automatic logic [DATA_WIDTH:0] fit(input logic signed [EW-1:0] v);
        logic                  fits;
        logic [DATA_WIDTH-1:0] val;
        fits = (&v[EW-1:DATA_WIDTH-1]) | ~(|v[EW-1:DATA_WIDTH-1]);
`ifdef BUTTERFLY_SAT_EN
        if (fits) begin
            val = v[DATA_WIDTH-1:0];
        end else if (v[EW-1]) begin
            val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`else
        val = v[DATA_WIDTH-1:0];
`endif
        return {~fits, val};
    endfunction

    cmult_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .TW_WIDTH  (TW_WIDTH)
    ) u_cmult (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .b_in  (but_b_in),
        .tw_in (but_tw),
        .wb_out(wb)
    );

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (en) begin
            s1_d = '{valid: but_valid_in, scale: but_scale_in, a: but_a_in};
            s2_d = s1_q;
        end
    end

    always_comb begin
        a_re   = s2_q.a[CW-1:DATA_WIDTH];
        a_im   = s2_q.a[DATA_WIDTH-1:0];
        wb_re  = wb[2*WW-1:WW];
        wb_im  = wb[WW-1:0];
        sum_re = {{2{a_re[DATA_WIDTH-1]}}, a_re} + {wb_re[WW-1], wb_re};
        sum_im = {{2{a_im[DATA_WIDTH-1]}}, a_im} + {wb_im[WW-1], wb_im};
        dif_re = {{2{a_re[DATA_WIDTH-1]}}, a_re} - {wb_re[WW-1], wb_re};
        dif_im = {{2{a_im[DATA_WIDTH-1]}}, a_im} - {wb_im[WW-1], wb_im};
        if (s2_q.scale) begin
            sum_re = sum_re >>> 1;
            sum_im = sum_im >>> 1;
            dif_re = dif_re >>> 1;
            dif_im = dif_im >>> 1;
        end
        f_sr = fit(sum_re);
        f_si = fit(sum_im);
        f_dr = fit(dif_re);
        f_di = fit(dif_im);

        valid_out_d = valid_out_q;
        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        ovf_d       = ovf_q;
        if (en) begin
            valid_out_d = s2_q.valid;
            a_out_d     = {f_sr[DATA_WIDTH-1:0], f_si[DATA_WIDTH-1:0]};
            b_out_d     = {f_dr[DATA_WIDTH-1:0], f_di[DATA_WIDTH-1:0]};
            ovf_d       = s2_q.valid
                          & (f_sr[DATA_WIDTH] | f_si[DATA_WIDTH] | f_dr[DATA_WIDTH] | f_di[DATA_WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            valid_out_q <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            valid_out_q <= valid_out_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign but_valid_out = valid_out_q;
    assign but_a_out     = a_out_q;
    assign but_b_out     = b_out_q;
    assign but_ovf_out   = ovf_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: directed vectors, backpressure and async reset.
module tb_butterfly_pipe;
    import fft_pkg::*;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic        ovf;
    } exp_t;

    logic        clk, rst_n;
    logic        ready_in, valid_in, scale_in, ready_out, valid_out, ovf_out;
    logic [23:0] a_in, b_in, tw_in, a_out, b_out;

    exp_t exp_q[$];
    exp_t e;
    int   checks, errors, n_out;

    butterfly_pipe dut (
        .clk          (clk),
        .rst          (rst_n),
        .but_ready_in (ready_in),
        .but_valid_in (valid_in),
        .but_a_in     (a_in),
        .but_b_in     (b_in),
        .but_tw       (tw_in),
        .but_scale_in (scale_in),
        .but_ready_out(ready_out),
        .but_valid_out(valid_out),
        .but_a_out    (a_out),
        .but_b_out    (b_out),
        .but_ovf_out  (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] cx(input int re, input int im);
        logic [11:0] r, i;
        r = re[11:0];
        i = im[11:0];
        return {r, i};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [23:0] tw,
                        input logic sc, input logic [23:0] ea, input logic [23:0] eb,
                        input logic eo);
        int g;
        exp_t x;
        g = 0;
        @(negedge clk);
        valid_in = 1'b1;
        a_in = a;
        b_in = b;
        tw_in = tw;
        scale_in = sc;
        #1;
        while (!ready_in && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (!ready_in) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_in got 0 required 1");
        end else begin
            x.a = ea;
            x.b = eb;
            x.ovf = eo;
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("drain_queue_empty", 24'(exp_q.size()), 24'd0);
    endtask

    // Monitor: compare every output handshake against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got a_out %h required no output", a_out);
                end else begin
                    e = exp_q.pop_front();
                    check("a_out", a_out, e.a);
                    check("b_out", b_out, e.b);
                    check("ovf_out", 24'(ovf_out), 24'(e.ovf));
                end
                n_out++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [23:0] held_a, held_b, eb3;
        checks = 0;
        errors = 0;
        n_out = 0;
        rst_n = 1'b0;
        valid_in = 1'b0;
        scale_in = 1'b0;
        ready_out = 1'b1;
        a_in = '0;
        b_in = '0;
        tw_in = '0;
        #12;
        check("reset_valid_out", 24'(valid_out), 24'd0);
        check("reset_ovf_out", 24'(ovf_out), 24'd0);
        check("reset_a_out", a_out, 24'd0);
        check("reset_b_out", b_out, 24'd0);
        check("reset_ready_in", 24'(ready_in), 24'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        send(cx(100, 0), cx(256, 0), cx(-2048, 0), 1'b0, cx(-156, 0), cx(356, 0), 1'b0);
        send(cx(0, 0), cx(3, 0), cx(1024, 0), 1'b0, cx(2, 0), cx(-2, 0), 1'b0);
`ifdef BUTTERFLY_SAT_EN
        eb3 = cx(2047, 0);
`else
        eb3 = cx(-96, 0);
`endif
        send(cx(2000, 0), cx(2000, 0), cx(-2048, 0), 1'b0, cx(0, 0), eb3, 1'b1);
        send(cx(2000, 0), cx(2000, 0), cx(-2048, 0), 1'b1, cx(0, 0), cx(2000, 0), 1'b0);
        send(cx(0, 0), cx(512, 512), cx(0, -2048), 1'b0, cx(512, -512), cx(-512, 512), 1'b0);
        send(cx(-300, 700), cx(100, -200), cx(1024, 1024), 1'b0,
             cx(-150, 650), cx(-450, 750), 1'b0);
        send(cx(-3, 0), cx(0, 0), cx(0, 0), 1'b1, cx(-2, 0), cx(-2, 0), 1'b0);
`ifdef BUTTERFLY_SAT_EN
        send(cx(0, -2000), cx(0, 2000), cx(-2048, 0), 1'b0, cx(0, -2048), cx(0, 0), 1'b1);
`else
        send(cx(0, -2000), cx(0, 2000), cx(-2048, 0), 1'b0, cx(0, 96), cx(0, 0), 1'b1);
`endif
        drain();

        // Backpressure: 4-cycle stall after the 2nd output of a 5-deep stream
        base = n_out;
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    send(cx(10 * i, -i), cx(i, 0), cx(-2048, 0), 1'b0,
                         cx(9 * i, -i), cx(11 * i, -i), 1'b0);
                end
            end
            begin
                int g;
                g = 0;
                while (n_out < base + 2 && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                check("stall_reached_2nd_output", 24'(n_out - base), 24'd2);
                ready_out = 1'b0;
                #2;
                held_a = a_out;
                held_b = b_out;
                for (int k = 0; k < 4; k++) begin
                    if (k != 0) begin
                        @(negedge clk);
                        #2;
                    end
                    check("stall_ready_in_low", 24'(ready_in), 24'd0);
                    check("stall_valid_held", 24'(valid_out), 24'd1);
                    check("stall_a_out_held", a_out, held_a);
                    check("stall_b_out_held", b_out, held_b);
                end
                @(negedge clk);
                ready_out = 1'b1;
                #1;
                check("stall_ready_in_restored", 24'(ready_in), 24'd1);
            end
        join
        drain();
        check("stream_output_count", 24'(n_out - base), 24'd5);

        // Asynchronous reset with data in flight
        send(cx(100, 0), cx(256, 0), cx(-2048, 0), 1'b0, cx(-156, 0), cx(356, 0), 1'b0);
        send(cx(0, 0), cx(3, 0), cx(1024, 0), 1'b0, cx(2, 0), cx(-2, 0), 1'b0);
        send(cx(2000, 0), cx(2000, 0), cx(-2048, 0), 1'b0, cx(0, 0), eb3, 1'b1);
        #2;
        check("pre_reset_valid_out", 24'(valid_out), 24'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid_out", 24'(valid_out), 24'd0);
        check("async_reset_a_out", a_out, 24'd0);
        check("async_reset_ovf_out", 24'(ovf_out), 24'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            check("post_reset_idle_valid", 24'(valid_out), 24'd0);
        end
        send(cx(0, 0), cx(512, 512), cx(0, -2048), 1'b0, cx(512, -512), cx(-512, 512), 1'b0);
        for (int k = 0; k < BUT_LATENCY - 1; k++) begin
            @(negedge clk);
            #2;
            check("latency_not_yet_valid", 24'(valid_out), 24'd0);
        end
        @(negedge clk);
        #2;
        check("latency_valid", 24'(valid_out), 24'd1);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
